// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: N-decade synchronous BCD up/down counter with load validation,
// wrap/saturate limits and a combinational terminal count for chaining stages.
module bcd_updown_counter_n #(
    parameter int NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up,
    input  logic                   sat,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   tc,
    output logic                   wrap,
    output logic                   load_err
);
    localparam int W = 4 * NDIGITS;

    logic [W-1:0]       count_q, count_d, step_val;
    logic               wrap_q, wrap_d, load_err_q, load_err_d;
    logic [NDIGITS:0]   c;
    logic [NDIGITS-1:0] digit_ok;

    // c[i] means digit i steps this cycle; c[NDIGITS] means every digit sits at the active limit
    assign c[0] = 1'b1;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        logic [3:0] d;
        assign d = count_q[4*i +: 4];
        assign c[i+1] = c[i] & (up ? d == 4'd9 : d == 4'd0);
        assign step_val[4*i +: 4] = !c[i] ? d :
                                    up ? (d == 4'd9 ? 4'd0 : d + 4'd1) :
                                         (d == 4'd0 ? 4'd9 : d - 4'd1);
        assign digit_ok[i] = load_val[4*i +: 4] <= 4'd9;
    end

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = &digit_ok ? load_val : count_q;
            load_err_d = ~&digit_ok;
        end else if (en) begin
            count_d = (c[NDIGITS] && sat) ? count_q : step_val;
            wrap_d  = c[NDIGITS] & ~sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = en & ~load & ~rst & c[NDIGITS];
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: directed checks of the 2-digit BCD counter with hand-computed values.
module tb_bcd_updown_counter_n;
    logic       clk = 1'b0;
    logic       rst, en, up, sat, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, wrap, load_err;
    int         checks = 0;
    int         failures = 0;

    bcd_updown_counter_n #(.NDIGITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] c, input logic w, input logic e);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
        chk({tag, ".load_err"}, 32'(load_err), 32'(e));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = 8'h00;
        tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0);

        rst = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        chk("up_tc_start", 32'(tc), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_state("up_count", 8'(((k / 10) << 4) | (k % 10)), 1'b0, 1'b0);
            chk("up_tc", 32'(tc), 32'd0);
        end

        en = 1'b0; load = 1'b1; load_val = 8'h98;
        tick();
        chk_state("load98", 8'h98, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        tick();
        chk_state("up99", 8'h99, 1'b0, 1'b0);
        chk("up99_tc", 32'(tc), 32'd1);
        tick();
        chk_state("upwrap00", 8'h00, 1'b1, 1'b0);
        tick();
        chk_state("upwrap01", 8'h01, 1'b0, 1'b0);

        en = 1'b0; load = 1'b1; load_val = 8'h01;
        tick();
        chk_state("load01", 8'h01, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        tick();
        chk_state("dn00", 8'h00, 1'b0, 1'b0);
        chk("dn00_tc", 32'(tc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_state("dn_sat_hold", 8'h00, 1'b0, 1'b0);
            chk("dn_sat_tc", 32'(tc), 32'd1);
        end
        sat = 1'b0;
        tick();
        chk_state("dn_wrap99", 8'h99, 1'b1, 1'b0);
        tick();
        chk_state("dn98", 8'h98, 1'b0, 1'b0);

        en = 1'b0; load = 1'b1; load_val = 8'h40;
        tick();
        chk_state("load40", 8'h40, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        chk_state("borrow39", 8'h39, 1'b0, 1'b0);
        tick();
        chk_state("borrow38", 8'h38, 1'b0, 1'b0);

        en = 1'b0; load = 1'b1; load_val = 8'h27;
        tick();
        chk_state("load27", 8'h27, 1'b0, 1'b0);
        load_val = 8'h5A;
        tick();
        chk_state("bad5A", 8'h27, 1'b0, 1'b1);
        load_val = 8'h59;
        tick();
        chk_state("load59", 8'h59, 1'b0, 1'b0);
        load_val = 8'hC3;
        tick();
        chk_state("badC3", 8'h59, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        chk_state("idle_hold", 8'h59, 1'b0, 1'b0);

        load = 1'b1; load_val = 8'h99;
        tick();
        chk_state("load99", 8'h99, 1'b0, 1'b0);
        en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b1; load_val = 8'h33;
        #1;
        chk("prio_tc_load", 32'(tc), 32'd0);
        tick();
        chk_state("prio_load33", 8'h33, 1'b0, 1'b0);
        load_val = 8'hAA; tick();
        chk_state("prio_badAA", 8'h33, 1'b0, 1'b1);
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'hAA;
        #1;
        chk("prio_tc_rst", 32'(tc), 32'd0);
        tick();
        chk_state("prio_rst", 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit synchronous BCD counter; successor to the single-digit 0-9 ripple BCD counter.
- Adds N cascaded decades, up/down direction, count enable, parallel load with BCD validation, wrap/saturate mode, and a terminal-count output for chaining.
- Fully synchronous to one clock; used for display/timer/event-count paths in the sequential-circuit designs.

Parameters:
NDIGITS, 2, number of BCD decades (1..8); counter width is 4*NDIGITS bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement
sat  input  1  mode: 0 = wrap at limits, 1 = saturate at limits
load  input  1  synchronous parallel load request
load_val  input  4*NDIGITS  BCD value to load; digit i = bits [4i+3:4i]
count  output  4*NDIGITS  current BCD count; digit 0 is least significant
tc  output  1  terminal count (combinational)
wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge
load_err  output  1  registered one-cycle pulse: the previous load was rejected

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk. It sets count=0, wrap=0 and load_err=0. rst has the highest priority.
- Priority on each edge: rst > load > en. When none of the three is active, count holds, and wrap and load_err go to 0.
- Load, valid case: every digit of load_val is <=9. count <= load_val next edge, load_err=0, wrap=0. en is ignored in that cycle.
- Load, invalid case: any digit is >9. count holds, load_err=1 for exactly one cycle, wrap=0.
- Up count (en=1, load=0, up=1): digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - A digit below 9 increments, and all higher digits hold.
- Down count (en=1, load=0, up=0): digit 0 decrements.
  - A digit at 0 rolls to 9 and borrows from the next digit.
- Limits: the upper limit is all digits 9 (10^NDIGITS - 1); the lower limit is 0.
  - Stepping past a limit with sat=0: count wraps to the opposite limit (99..9 -> 0, 0 -> 99..9), and wrap=1 on the following cycle.
  - Stepping past a limit with sat=1: count holds at the limit, wrap=0.
- Latency: count reflects a step, load or reset one cycle after the qualifying edge. wrap and load_err are valid in that same cycle as the updated count.
- tc = en & ~load & ~rst & (up ? count==all-9s : count==0). It is combinational, independent of sat, and intended as the en input of a following counter stage.
- Non-BCD state is unreachable: count never holds a digit >9 by any input sequence.
- Changing up or sat mid-count takes effect on the next enabled edge; there is no pipeline to flush.
- A load that coincides with a limit crossing: the load wins, and no wrap pulse is produced.
- rst asserted together with load or en: reset wins, and all outputs return to reset values.
- Arithmetic is per-digit 4-bit with carry/borrow chained combinationally across digits; there is no binary-to-BCD conversion.

Test Plan:
- Reset and up count (NDIGITS=2): rst=1 for 1 cycle, then en=1, up=1 for 12 cycles -> count 00,01..09,10,11,12; tc=0 throughout; wrap=0.
- Up wrap: load 0x98, then en=1, up=1, sat=0 -> count 99 with tc=1, then 00 with wrap=1 for exactly one cycle, then 01 with wrap=0.
- Down count and saturation: load 0x01, then en=1, up=0, sat=1 -> count 00 with tc=1, then held at 00 for 3 more cycles, wrap never set. Repeat with sat=0 -> count 00, then 99 with wrap=1.
- Cross-digit borrow: load 0x40, en=1, up=0 -> count 39, then 38; the upper digit changes only on the 40->39 step.
- Load validation: load_val=0x5A with load=1 while count=0x27 -> count stays 27 and load_err=1 for one cycle. Then load_val=0x59 -> count 59, load_err=0.
- Priority: count=0x99, en=1, up=1, load=1, load_val=0x33 -> count 33, no wrap. Next cycle rst=1 with en=1 and load=1 -> count 00, wrap=0, load_err=0.
